// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver.
//   clks_per_bit : PCLK cycles per line bit (integer division)
//   cnt_width    : register width able to hold 0..n-1 (at least 1 bit)
//   line_state_t : line-level FSM states shared by both directions
//   IDLE_LEVEL   : level of an idle UART line
package uart_pkg;

    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } line_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 while run is high and
// wraps on its own, so consecutive bits need no restart.
// Ports:
//   pclk, preset : clock, asynchronous active-high reset
//   clear        : synchronous return of the count to 0 (wins over run)
//   run          : advance the count
//   bit_tick     : high on the last cycle of every bit period
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic pclk,
    input  logic preset,
    input  logic clear,
    input  logic run,
    output logic bit_tick
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign bit_tick = run & (count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// 8N1-style UART transmitter with a one-entry holding register so the
// next byte can be queued while a frame is on the line.
// Ports:
//   PCLK, PRESET : clock, asynchronous active-high reset
//   tx_en        : enable; when low new requests are ignored silently
//   tx_rst       : synchronous soft reset, highest priority
//   tx_start     : one-cycle request to send tx_data
//   tx_data      : byte captured when tx_start is accepted
//   tx_serial    : registered serial line, idles high
//   tx_ready     : holding register empty
//   tx_busy      : frame in progress
//   tx_done      : pulse on the last cycle of each stop bit
//   tx_error     : pulse the cycle after a request dropped by overrun
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int BAUD_RATE = 9600,
    parameter int CLK_FREQ  = 100_000_000,
    parameter int DATA_BITS = 8
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 tx_en,
    input  logic                 tx_rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_serial,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_error
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int BIT_W = cnt_width(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    line_state_t          state, state_next;
    logic [DATA_BITS-1:0] shift_q, shift_next;
    logic [DATA_BITS-1:0] hold_q, hold_next;
    logic                 hold_valid, hold_valid_next;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
    logic                 serial_next;
    logic                 error_next;
    logic                 bit_tick;
    logic                 accept;
    logic                 last_stop;
    logic [DATA_BITS-1:0] shifted;

    assign accept    = tx_start & tx_en;
    assign last_stop = (state == STOP) & bit_tick;
    assign shifted   = shift_q >> 1;

    // Counter is parked at 0 in IDLE so START always gets a full period.
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .pclk    (PCLK),
        .preset  (PRESET),
        .clear   (tx_rst | (state == IDLE)),
        .run     (state != IDLE),
        .bit_tick(bit_tick)
    );

    assign tx_busy  = (state != IDLE);
    assign tx_ready = ~hold_valid;
    assign tx_done  = last_stop & ~tx_rst;

    always_comb begin
        state_next      = state;
        shift_next      = shift_q;
        hold_next       = hold_q;
        hold_valid_next = hold_valid;
        bit_cnt_next    = bit_cnt;
        serial_next     = tx_serial;
        error_next      = 1'b0;

        if (tx_rst) begin
            state_next      = IDLE;
            shift_next      = '0;
            hold_next       = '0;
            hold_valid_next = 1'b0;
            bit_cnt_next    = '0;
            serial_next     = IDLE_LEVEL;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_next   = tx_data;
                        bit_cnt_next = '0;
                        state_next   = START;
                        serial_next  = 1'b0;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state_next  = DATA;
                        serial_next = shift_q[0];
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift_next = shifted;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt_next = '0;
                            state_next   = STOP;
                            serial_next  = IDLE_LEVEL;
                        end else begin
                            bit_cnt_next = bit_cnt + 1'b1;
                            serial_next  = shifted[0];
                        end
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        bit_cnt_next = '0;
                        if (hold_valid) begin
                            shift_next      = hold_q;
                            hold_valid_next = 1'b0;
                            state_next      = START;
                            serial_next     = 1'b0;
                        end else if (accept) begin
                            // Holding empty on the final stop cycle: bypass it
                            // so the new byte follows without a gap.
                            shift_next  = tx_data;
                            state_next  = START;
                            serial_next = 1'b0;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: begin
                    state_next  = IDLE;
                    serial_next = IDLE_LEVEL;
                end
            endcase

            if (accept && (state != IDLE)) begin
                if (hold_valid) begin
                    error_next = 1'b1;
                end else if (!last_stop) begin
                    hold_next       = tx_data;
                    hold_valid_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= IDLE;
            shift_q    <= '0;
            hold_q     <= '0;
            hold_valid <= 1'b0;
            bit_cnt    <= '0;
            tx_serial  <= IDLE_LEVEL;
            tx_error   <= 1'b0;
        end else begin
            state      <= state_next;
            shift_q    <= shift_next;
            hold_q     <= hold_next;
            hold_valid <= hold_valid_next;
            bit_cnt    <= bit_cnt_next;
            tx_serial  <= serial_next;
            tx_error   <= error_next;
        end
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serial UART transmitter that is the counterpart of uart_receiver in the APB UART IP. It takes parallel bytes from the APB register block and drives 8N1 frames onto tx_serial: a start bit, DATA_BITS data bits LSB first, then one stop bit. A one-entry holding register lets firmware queue the next byte while the current frame is on the line, so consecutive frames go out back-to-back.

Parameters:
BAUD_RATE, 9600, line rate in bit/s.
CLK_FREQ, 100_000_000, PCLK frequency in Hz.
DATA_BITS, 8, data bits per frame.

Ports:
PCLK  input  1  system clock, rising-edge.
PRESET  input  1  asynchronous, active-high reset.
tx_en  input  1  transmitter enable.
tx_rst  input  1  synchronous soft reset.
tx_start  input  1  single-cycle request to send tx_data.
tx_data  input  DATA_BITS  byte to send, sampled when tx_start is accepted.
tx_serial  output  1  serial line; idles high; registered.
tx_ready  output  1  holding register empty.
tx_busy  output  1  frame in progress (state != IDLE).
tx_done  output  1  one-cycle pulse at the end of each stop bit.
tx_error  output  1  one-cycle pulse when a byte is dropped because of overrun.

Behaviour:
- Clocking and reset are fixed: one clock, PCLK. PRESET is asynchronous and active-high.
- Bit timing: CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, using integer division (10416 at the defaults). Every line state, start, each data bit and stop, lasts exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1 and restarts on every bit boundary.
- Reset values (PRESET, or tx_rst while PRESET is low):
  - tx_serial=1, tx_busy=0, tx_done=0, tx_error=0, tx_ready=1.
  - State goes to IDLE; the holding register and both counters are cleared.
- FSM states are IDLE, START, DATA and STOP.
  - IDLE: when tx_start=1 and tx_en=1, load the shift register with tx_data, clear the counters and go to START. tx_serial goes to 0 on that same edge, so the line is low from the next cycle: one cycle of latency.
  - START: line 0 for CLKS_PER_BIT cycles, then go to DATA with tx_serial=shift[0].
  - DATA: shift right at each bit end and increment the bit counter. After bit DATA_BITS-1 go to STOP with tx_serial=1.
  - STOP: line 1 for CLKS_PER_BIT cycles. On the last cycle, pulse tx_done, then:
    - if the holding register is valid, move it to the shift register, clear it and go straight to START (no idle gap);
    - otherwise go to IDLE.
- Holding register:
  - tx_start with tx_en=1 while tx_busy=1 and tx_ready=1 captures tx_data into holding, and tx_ready drops to 0 on the next cycle.
  - tx_start while tx_ready=0 pulses tx_error for one cycle on the next cycle. The byte is dropped, and holding and the current frame are unaffected.
- tx_en=0: tx_start is ignored with no error pulse. A frame in progress and any valid holding byte still complete, so the line is never truncated.
- Simultaneous events:
  - tx_rst has priority over everything.
  - tx_start on the final STOP cycle with holding empty is loaded straight into the shift register and sent next, with no gap.
  - tx_start on the final STOP cycle with holding full is an overrun (tx_error). The holding byte is sent.
- Reset mid-frame: tx_serial returns to 1 immediately (PRESET) or on the next edge (tx_rst). The aborted frame is not resumed.
- tx_data is not used after capture; changing it later has no effect.

Decomposition:
- Shared package uart_pkg:
  - CLKS_PER_BIT computation as a function of CLK_FREQ and BAUD_RATE.
  - Counter width via $clog2.
  - Line state enum IDLE/START/DATA/STOP, shared with uart_receiver.
  - IDLE_LEVEL=1'b1.
- One sub-module, uart_baud_gen: the bit-period counter.
  - Inputs: clear, run.
  - Output: bit_tick on count CLKS_PER_BIT-1.
  - It is reusable by the receiver.

Test Plan:
1. Single byte 0x16 at t0 → tx_serial is 0 from cycle t0+1 and holds each level for 10416 cycles. Bit sequence: 0, 0,1,1,0,1,0,0,0, 1. tx_done pulses once at t0+104160, tx_busy deasserts on the next cycle, and a uart_receiver loopback gives rx_data=0x16 with rx_error=0.
2. Back-to-back 0x32 then 0xAF, the second issued while busy → tx_ready drops. The second start bit begins exactly 104160 cycles after the first, the loopback receives 0x32 then 0xAF, and the two tx_done pulses are 104160 cycles apart.
3. Overrun: 0x32 sending, 0xAF held, then tx_start with 0x55 → tx_error is a single-cycle pulse. Only 0x32 and 0xAF appear on the line, and 0x55 is never transmitted.
4. tx_rst during data bit 3 of 0xAF → tx_serial=1 and tx_busy=0 on the next cycle, tx_ready=1, no tx_done pulse. A subsequent 0x16 is transmitted correctly.
5. tx_en=0 with a tx_start pulse → tx_serial stays 1 and tx_busy and tx_error stay 0. Deasserting tx_en mid-frame still completes 0x32.
6. PRESET asserted asynchronously mid-stop-bit → all outputs go to their reset values without waiting for a PCLK edge, and the line stays high after release.
